// File: rtl/seq_alu_if.sv
// ============================================================================
// Module   : seq_alu_if
// Brief    : Request/response bundle between the EX-stage controller and seq_alu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             start_i;
    logic [3:0]       ALUCtrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             done_o;
    logic             illegal_o;
    logic             busy_o;

    modport master (
        output start_i, ALUCtrl_i, src1_i, src2_i,
        input  result_o, zero_o, done_o, illegal_o, busy_o
    );

    modport slave (
        input  start_i, ALUCtrl_i, src1_i, src2_i,
        output result_o, zero_o, done_o, illegal_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module   : seq_alu
// Brief    : Multi-cycle ALU; logic/arith ops in one cycle, MUL by WIDTH-step shift-add.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu #(
    parameter int WIDTH = 32
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    seq_alu_if.slave  bus
);
    localparam int              c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;
    localparam logic [3:0] c_OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_done;
    logic              r_illegal;

    logic [WIDTH-1:0]  w_alu_res;
    logic              w_legal;
    logic              w_is_mul;
    logic [WIDTH-1:0]  w_acc_next;

    // Unknown or X codes fall to default, so they report illegal with a zero result.
    always_comb begin
        w_alu_res = '0;
        w_legal   = 1'b1;
        w_is_mul  = 1'b0;
        case (bus.ALUCtrl_i)
            c_OP_AND: w_alu_res = bus.src1_i & bus.src2_i;
            c_OP_OR:  w_alu_res = bus.src1_i | bus.src2_i;
            c_OP_ADD: w_alu_res = bus.src1_i + bus.src2_i;
            c_OP_SUB: w_alu_res = bus.src1_i - bus.src2_i;
            c_OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}},
                                   ($signed(bus.src1_i) < $signed(bus.src2_i))};
            c_OP_NOR: w_alu_res = ~(bus.src1_i | bus.src2_i);
            c_OP_MUL: w_is_mul  = 1'b1;
            default:  w_legal   = 1'b0;
        endcase
    end

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        if (w_is_mul) begin
                            r_acc    <= '0;
                            r_mcand  <= bus.src1_i;
                            r_mplier <= bus.src2_i;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_result  <= w_alu_res;
                            r_zero    <= (w_alu_res == '0);
                            r_illegal <= ~w_legal;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    // Fixed WIDTH iterations; no early exit when the multiplier runs out of ones.
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_result  <= w_acc_next;
                        r_zero    <= (w_acc_next == '0);
                        r_illegal <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result_o  = r_result;
    assign bus.zero_o    = r_zero;
    assign bus.done_o    = r_done;
    assign bus.illegal_o = r_illegal;
    assign bus.busy_o    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Self-checking bench for seq_alu against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] r,
                                      output logic ill);
        logic [2*W-1:0] p;
        ill = 1'b0;
        r   = '0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = W'(a + b);
            4'b0110: r = W'(a - b);
            4'b0111: r = (longint'($signed(a)) < longint'($signed(b))) ? W'(1) : W'(0);
            4'b1100: r = ~(a | b);
            4'b1000: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = p[W-1:0];
            end
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        return (op == 4'b1000) ? W + 1 : 1;
    endfunction

    // Issues one request and waits (bounded) for its done pulse; lat = -1 on timeout.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic z, output logic ill,
                          output int lat, output int busy_cnt);
        bit seen;
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.src1_i    = a;
        bus.src2_i    = b;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        lat = 0; busy_cnt = 0; seen = 0;
        res = '0; z = 1'b0; ill = 1'b0;
        while (!seen && lat < W + 10) begin
            @(negedge clk);
            lat++;
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) begin
                seen = 1;
                res  = bus.result_o;
                z    = bus.zero_o;
                ill  = bus.illegal_o;
            end
        end
        if (!seen) lat = -1;
    endtask

    task automatic check_op(input string name, input logic [3:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] res, exp_r;
        logic z, ill, exp_ill;
        int lat, bc;
        run_op(op, a, b, res, z, ill, lat, bc);
        ref_model(op, a, b, exp_r, exp_ill);
        n_cmp++;
        if (res !== exp_r || z !== (exp_r == '0) || ill !== exp_ill) begin
            n_bad++;
            $display("FAIL %s result: got r=%h z=%b ill=%b expected r=%h z=%b ill=%b (op=%b a=%h b=%h)",
                     name, res, z, ill, exp_r, (exp_r == '0), exp_ill, op, a, b);
        end
        n_cmp++;
        if (lat !== ref_lat(op) || bc !== ref_lat(op)) begin
            n_bad++;
            $display("FAIL %s latency: got lat=%0d busy=%0d expected %0d", name, lat, bc, ref_lat(op));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.result_o, bus.zero_o, bus.done_o, bus.illegal_o, bus.busy_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got r=%h z=%b d=%b i=%b b=%b expected all 0",
                     bus.result_o, bus.zero_o, bus.done_o, bus.illegal_o, bus.busy_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        check_op("add_5_7", 4'b0010, 32'd5, 32'd7);
        @(negedge clk);
        n_cmp++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 32'd12) begin
            n_bad++;
            $display("FAIL add_after_done: got d=%b b=%b r=%0d expected d=0 b=0 r=12",
                     bus.done_o, bus.busy_o, bus.result_o);
        end
    endtask

    task automatic test_wrap_zero();
        check_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1);
        check_op("sub_zero", 4'b0110, 32'd3, 32'd3);
        check_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
        check_op("or", 4'b0001, 32'hF000_0001, 32'h0000_1000);
        check_op("nor", 4'b1100, 32'hAAAA_0000, 32'h5555_0000);
    endtask

    task automatic test_slt();
        check_op("slt_neg1_1", 4'b0111, 32'hFFFF_FFFF, 32'd1);
        check_op("slt_max_min", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
        check_op("slt_min_max", 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF);
    endtask

    task automatic test_mul();
        check_op("mul_1234_5678", 4'b1000, 32'd1234, 32'd5678);
        check_op("mul_ff_ff", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_op("mul_zero", 4'b1000, 32'h0001_0000, 32'h0001_0000);
    endtask

    task automatic test_illegal();
        check_op("illegal_0101", 4'b0101, 32'd9, 32'd4);
        check_op("illegal_1111", 4'b1111, 32'd1, 32'd1);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, exp_r, res;
        logic ill;
        int ndone, done_at;
        a1 = $urandom; b1 = $urandom;
        ref_model(4'b1000, a1, b1, exp_r, ill);
        @(negedge clk);
        bus.start_i = 1'b1; bus.ALUCtrl_i = 4'b1000; bus.src1_i = a1; bus.src2_i = b1;
        @(posedge clk);
        ndone = 0; done_at = -1; res = '0;
        for (int i = 1; i <= W + 6; i++) begin
            @(negedge clk);
            if (bus.done_o) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = i;
                    res = bus.result_o;
                end
                bus.start_i = 1'b0;
            end else if (done_at < 0) begin
                bus.ALUCtrl_i = (i % 2 == 0) ? 4'b1000 : 4'b0010;
                bus.src1_i = $urandom; bus.src2_i = $urandom;
            end
        end
        bus.start_i = 1'b0;
        n_cmp++;
        if (ndone !== 1 || done_at !== W + 1 || res !== exp_r) begin
            n_bad++;
            $display("FAIL mul_ignore_start: got dones=%0d at=%0d r=%h expected 1 at %0d r=%h",
                     ndone, done_at, res, W + 1, exp_r);
        end

        // Hold start high across two single-cycle ops: the second waits out the DONE cycle.
        @(negedge clk);
        bus.start_i = 1'b1; bus.ALUCtrl_i = 4'b0010; bus.src1_i = 32'd100; bus.src2_i = 32'd23;
        @(negedge clk);
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.result_o !== 32'd123) begin
            n_bad++;
            $display("FAIL b2b_first: got d=%b b=%b r=%0d expected d=1 b=1 r=123",
                     bus.done_o, bus.busy_o, bus.result_o);
        end
        bus.ALUCtrl_i = 4'b0110; bus.src1_i = 32'd50; bus.src2_i = 32'd8;
        @(negedge clk);
        n_cmp++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap: got b=%b d=%b expected b=0 d=0", bus.busy_o, bus.done_o);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'd42) begin
            n_bad++;
            $display("FAIL b2b_second: got d=%b r=%0d expected d=1 r=42", bus.done_o, bus.result_o);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        int ndone;
        check_op("pre_reset_add", 4'b0010, 32'd5, 32'd7);
        @(negedge clk);
        bus.start_i = 1'b1; bus.ALUCtrl_i = 4'b1000; bus.src1_i = 32'd77; bus.src2_i = 32'd99;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus.busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL mul_busy_before_reset: got %b expected 1", bus.busy_o);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.result_o, bus.zero_o, bus.done_o, bus.illegal_o, bus.busy_o} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got r=%h z=%b d=%b i=%b b=%b expected all 0",
                     bus.result_o, bus.zero_o, bus.done_o, bus.illegal_o, bus.busy_o);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_bad++;
            $display("FAIL reset_no_done: got %0d active cycles expected 0", ndone);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [10];
        logic [3:0] op;
        logic [W-1:0] a, b;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                4'b1100, 4'b1000, 4'b0101, 4'b1111, 4'b0011};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 9)];
            a  = $urandom;
            b  = (i % 7 == 0) ? a : $urandom;
            check_op("random", op, a, b);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.ALUCtrl_i = 4'b0000;
        bus.src1_i = '0;
        bus.src2_i = '0;
        test_reset();
        test_add();
        test_wrap_zero();
        test_slt();
        test_mul();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle execution unit at the consuming end of the ALU control interface.
- Accepts the 4-bit ALU control code plus two operands under a start/done handshake.
- Logical and arithmetic ops complete in one cycle; MUL runs an iterative shift-add over WIDTH cycles.
- Sits in the EX stage of the multi-cycle datapath; the controller stalls on busy_o.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be ≥ 2. The MUL iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  request; sampled only in IDLE
- ALUCtrl_i  input  4  operation code, latched with start
- src1_i  input  WIDTH  operand A, latched with start
- src2_i  input  WIDTH  operand B, latched with start
- result_o  output  WIDTH  registered result; held until the next done
- zero_o  output  1  registered; high when result_o == 0
- done_o  output  1  one-cycle pulse; result_o/zero_o/illegal_o valid in this cycle
- illegal_o  output  1  registered; high with done when the code is unsupported
- busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_i=1): state=IDLE, result_o=0, zero_o=0, done_o=0, illegal_o=0, busy_o=0, internal accumulator/counter cleared.
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed: result=1 if $signed(A)<$signed(B), else 0)
  - 1100 NOR
  - 1000 MUL (low WIDTH bits of A*B)
  - All other codes are illegal.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. No overflow flag. SLT uses a true signed compare, correct across overflow. MUL low bits are sign-agnostic.
- States: IDLE, MUL, DONE.
- IDLE:
  - If start_i=1, latch ALUCtrl_i, src1_i and src2_i.
  - Single-cycle or illegal code: compute result and go to DONE.
  - MUL: acc=0, mcand=A, mplier=B, cnt=0, go to MUL.
  - If start_i=0, stay in IDLE.
- MUL: each cycle:
  - If mplier[0]=1, acc += mcand (mod 2^WIDTH).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt reaches WIDTH-1 (the WIDTH-th iteration), write result and go to DONE.
  - Early termination is not permitted; latency is fixed.
- DONE: done_o=1 for exactly this cycle, then IDLE unconditionally. start_i is ignored in DONE.
- Latency: start accepted at edge N (state IDLE).
  - Single-cycle ops: done_o high in cycle N+1.
  - MUL: done_o high in cycle N+1+WIDTH (N+33 at default).
  - Earliest next accept is edge N+2 (single-cycle) or N+2+WIDTH (MUL).
- Outputs at done:
  - result_o, zero_o and illegal_o update on the edge entering DONE and hold until the next entry into DONE.
  - Illegal code: result_o=0, zero_o=1, illegal_o=1.
  - Legal op: illegal_o=0.
- busy_o: high from the cycle after accept through the DONE cycle inclusive.
- start_i while busy: ignored, with no queuing. Operand or code changes while busy have no effect.
- Reset mid-operation: immediate return to IDLE, all outputs cleared, no done pulse. The aborted operation is lost.
- X or undefined ALUCtrl_i never propagates: default branch = illegal.

Test Plan:
- ADD: A=5, B=7, code 0010, start at N → done_o=1 at N+1, result_o=12, zero_o=0, illegal_o=0, busy_o high only at N+1.
- Wrap/zero: ADD A=0xFFFFFFFF, B=1 → result_o=0, zero_o=1. SUB A=3, B=3 → result_o=0, zero_o=1.
- SLT signed: A=0xFFFFFFFF(-1), B=1 → result_o=1. A=0x7FFFFFFF, B=0x80000000 → result_o=0.
- MUL: A=1234, B=5678, code 1000 → busy_o high 33 cycles, done_o only at N+33, result_o=7006652. A=0xFFFFFFFF, B=0xFFFFFFFF → result_o=1.
- Handshake: pulse start_i every cycle during a MUL with different operands → exactly one done_o, result from the first operands. Next start is accepted only after busy_o falls.
- Illegal/reset: code 0101 → done_o=1, illegal_o=1, result_o=0. Separately, assert rst_i at cycle 10 of a MUL → busy_o=0 immediately, all outputs 0, no done_o.
